imem_loader: RTL and testbench

- Program loader, the writer side of the instruction memory that the POCO-R pipeline fetches from.
- Receives a framed byte stream on a valid/ready interface and assembles big-endian 16-bit instruction words.
- Writes the words into imem through its write port, starting at address 0.
- Holds the CPU core in reset until a frame with a correct checksum has been fully loaded.

---
 rtl/poco_loader_pkg.sv | 30 +++
 rtl/imem_loader.sv | 185 ++++++++++++++++++
 tb/tb_imem_loader.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/poco_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : poco_loader_pkg
// Description : Shared definitions for the POCO-R program loader.
//               Holds the loader state encoding, the frame sync byte and the
//               checksum accumulator width.
// Revision    : 1.0 - initial release
// ============================================================================
package poco_loader_pkg;

    // Start-of-frame marker
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Width of the modular frame checksum
    localparam int CHK_W = 8;

    // Loader states; encoding fixed so waveforms stay comparable across builds
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_H  = 3'd1,
        ST_LEN_L  = 3'd2,
        ST_DATA_H = 3'd3,
        ST_DATA_L = 3'd4,
        ST_CHK    = 3'd5,
        ST_DONE   = 3'd6,
        ST_ERR    = 3'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Writer side of the POCO-R instruction memory. Parses a framed
//               byte stream (A5, LEN_H, LEN_L, LEN x {hi,lo}, CHK), writes the
//               big-endian 16-bit words to imem from address 0 and holds the
//               CPU core in reset until a frame with a valid checksum loads.
// Ports       : clk, rst        - clock, asynchronous active-high reset
//               in_valid/in_data/in_ready - byte stream (valid/ready)
//               reload          - pulse: leave DONE and re-arm
//               imem_we/imem_waddr/imem_wdata - imem write port
//               cpu_rst         - active-high reset to the CPU core
//               done, err       - load completed / last frame aborted
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import poco_loader_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [15:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    localparam int                 c_CNT_W    = ADDR_W + 1;
    localparam int                 c_TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [16:0]        c_CAPACITY = 17'(1) << ADDR_W;
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [15:0]         r_len;
    logic [7:0]          r_hi;
    logic [CHK_W-1:0]    r_sum;
    logic [CHK_W-1:0]    w_sum_add;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_TMO_W-1:0]  r_tmo;
    logic                r_we;
    logic [ADDR_W-1:0]   r_waddr;
    logic [15:0]         r_wdata;
    logic                r_cpu_rst;
    logic                r_done;
    logic                r_err;
    logic                w_ready;
    logic                w_accept;
    logic                w_in_frame;
    logic                w_timeout;
    logic                w_sync;
    logic [16:0]         w_len_field;
    logic [16:0]         w_cnt_next;

    assign w_ready     = (r_state != ST_DONE);
    assign w_accept    = in_valid && w_ready;
    assign w_sync      = (in_data == SYNC_BYTE);
    assign w_sum_add   = r_sum + in_data;
    // Length as it will be once LEN_L is latched; one extra bit so that a
    // length of exactly the memory capacity is representable.
    assign w_len_field = {1'b0, r_len[15:8], in_data};
    assign w_cnt_next  = 17'(r_cnt) + 17'd1;

    assign w_in_frame = (r_state == ST_LEN_H)  || (r_state == ST_LEN_L) ||
                        (r_state == ST_DATA_H) || (r_state == ST_DATA_L) ||
                        (r_state == ST_CHK);
    // The TIMEOUT-th consecutive idle cycle inside a frame aborts it
    assign w_timeout  = w_in_frame && !w_accept && (r_tmo == c_TMO_LAST);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_ERR: begin
                if (w_accept && w_sync) w_state_next = ST_LEN_H;
            end
            ST_LEN_H: begin
                if (w_accept) w_state_next = ST_LEN_L;
            end
            ST_LEN_L: begin
                if (w_accept) begin
                    if (w_len_field > c_CAPACITY)   w_state_next = ST_ERR;
                    else if (w_len_field == 17'd0)  w_state_next = ST_CHK;
                    else                            w_state_next = ST_DATA_H;
                end
            end
            ST_DATA_H: begin
                if (w_accept) w_state_next = ST_DATA_L;
            end
            ST_DATA_L: begin
                if (w_accept) begin
                    if (w_cnt_next == {1'b0, r_len}) w_state_next = ST_CHK;
                    else                             w_state_next = ST_DATA_H;
                end
            end
            ST_CHK: begin
                if (w_accept) w_state_next = (w_sum_add == '0) ? ST_DONE : ST_ERR;
            end
            ST_DONE: begin
                if (reload) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
        if (w_timeout) w_state_next = ST_ERR;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_len     <= '0;
            r_hi      <= '0;
            r_sum     <= '0;
            r_cnt     <= '0;
            r_tmo     <= '0;
            r_we      <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_cpu_rst <= 1'b1;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            // Status flags follow the state being entered so they line up
            // with the state register rather than lagging it.
            r_cpu_rst <= (w_state_next != ST_DONE);
            r_done    <= (w_state_next == ST_DONE);
            r_err     <= (w_state_next == ST_ERR);
            r_we      <= 1'b0;

            if (!w_in_frame || w_accept || w_timeout) r_tmo <= '0;
            else                                      r_tmo <= r_tmo + 1'b1;

            if (w_accept) begin
                case (r_state)
                    ST_IDLE, ST_ERR: begin
                        if (w_sync) begin
                            r_sum <= '0;
                            r_cnt <= '0;
                        end
                    end
                    ST_LEN_H: begin
                        r_len[15:8] <= in_data;
                        r_sum       <= w_sum_add;
                    end
                    ST_LEN_L: begin
                        r_len[7:0] <= in_data;
                        r_sum      <= w_sum_add;
                    end
                    ST_DATA_H: begin
                        r_hi  <= in_data;
                        r_sum <= w_sum_add;
                    end
                    ST_DATA_L: begin
                        r_we    <= 1'b1;
                        r_waddr <= r_cnt[ADDR_W-1:0];
                        r_wdata <= {r_hi, in_data};
                        r_cnt   <= r_cnt + 1'b1;
                        r_sum   <= w_sum_add;
                    end
                    ST_CHK: begin
                        r_sum <= w_sum_add;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign in_ready   = w_ready;
    assign imem_we    = r_we;
    assign imem_waddr = r_waddr;
    assign imem_wdata = r_wdata;
    assign cpu_rst    = r_cpu_rst;
    assign done       = r_done;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader. A frame model derives the
//               expected imem writes and final status from the frame bytes;
//               a compare process checks every write and the status
//               invariants each cycle; directed tests add literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 1024;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              reload;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [15:0]       imem_wdata;
    logic              cpu_rst;
    logic              done;
    logic              err;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] tx[$];
    int         exp_addr[$];
    int         exp_data[$];
    int         wr_count   = 0;
    int         last_waddr = -1;
    int         last_wdata = -1;
    logic       m_done;
    logic       m_err;

    imem_loader #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Frame model: expected writes and outcome computed from the bytes in tx
    task automatic model_tx();
        int i;
        int n;
        int sum;
        m_done = 1'b0;
        m_err  = 1'b0;
        i = 0;
        while (i < tx.size() && tx[i] != 8'hA5) i++;
        if (i + 2 >= tx.size()) return;
        n = int'(tx[i+1]) * 256 + int'(tx[i+2]);
        if (n > (1 << ADDR_W)) begin
            m_err = 1'b1;
            return;
        end
        sum = int'(tx[i+1]) + int'(tx[i+2]);
        for (int k = 0; k < n; k++) begin
            exp_addr.push_back(k);
            exp_data.push_back(int'(tx[i+3+2*k]) * 256 + int'(tx[i+4+2*k]));
            sum += int'(tx[i+3+2*k]) + int'(tx[i+4+2*k]);
        end
        sum += int'(tx[i+3+2*n]);
        if ((sum % 256) == 0) m_done = 1'b1;
        else                  m_err  = 1'b1;
    endtask

    task automatic send_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            in_valid = 1'b1;
            in_data  = tx[i];
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_done"},    int'(done),    int'(m_done));
        chk({tag, "_err"},     int'(err),     int'(m_err));
        chk({tag, "_cpu_rst"}, int'(cpu_rst), int'(!m_done));
        chk({tag, "_missing_writes"}, exp_addr.size(), 0);
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
    endtask

    // Every-cycle compare: write port against the model queue plus the
    // status relations that hold in every state.
    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready_vs_done", int'(in_ready), int'(!done));
            chk("cpu_rst_vs_done",  int'(cpu_rst),  int'(!done));
            if (imem_we) begin
                wr_count++;
                last_waddr = int'(imem_waddr);
                last_wdata = int'(imem_wdata);
                if (exp_addr.size() == 0) begin
                    chk("unexpected_write", int'(imem_waddr), -1);
                end else begin
                    chk("waddr", int'(imem_waddr), exp_addr.pop_front());
                    chk("wdata", int'(imem_wdata), exp_data.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        reload   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_imem_we", int'(imem_we),  0);
        chk("rst_cpu_rst", int'(cpu_rst),  1);
        chk("rst_done",    int'(done),     0);
        chk("rst_err",     int'(err),      0);
        chk("rst_in_ready",int'(in_ready), 1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Normal two-word load
        tx = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        model_tx();
        chk("model_w0", exp_data[0], 'h1234);
        chk("model_w1", exp_data[1], 'hABCD);
        wr_count = 0;
        send_range(0, 6);
        chk("pre_chk_cpu_rst", int'(cpu_rst), 1);
        send_range(7, 7);
        check_status("good1");
        chk("good1_done_lit",   int'(done),     1);
        chk("good1_in_ready",   int'(in_ready), 0);
        chk("good1_wr_count",   wr_count,       2);
        chk("good1_last_data",  last_wdata,     'hABCD);
        // Bytes offered while DONE are not taken
        in_valid = 1'b1;
        in_data  = 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("done_hold", int'(done), 1);
        do_reload();
        chk("reload_done",     int'(done),     0);
        chk("reload_cpu_rst",  int'(cpu_rst),  1);
        chk("reload_in_ready", int'(in_ready), 1);

        // Bad checksum
        tx = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
        model_tx();
        wr_count = 0;
        send_range(0, 7);
        check_status("badchk");
        chk("badchk_err_lit",  int'(err), 1);
        chk("badchk_wr_count", wr_count,  2);
        do_reload();
        chk("reload_ignored_in_err", int'(err), 1);

        // Good frame from ERR: sync byte clears err
        tx = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        model_tx();
        send_range(0, 0);
        chk("sync_clears_err", int'(err), 0);
        send_range(1, 7);
        check_status("recover");
        do_reload();

        // Garbage before an empty frame (N=0, checksum byte 00)
        tx = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h00, 8'h00};
        model_tx();
        wr_count = 0;
        send_range(0, 6);
        check_status("empty");
        chk("empty_wr_count", wr_count, 0);
        do_reload();

        // Length one above capacity
        tx = '{8'hA5, 8'h01, 8'h01};
        model_tx();
        wr_count = 0;
        send_range(0, 2);
        check_status("toolong");
        chk("toolong_err_lit", int'(err), 1);
        repeat (2) @(posedge clk);
        #1;
        chk("toolong_wr_count", wr_count, 0);

        // Exactly full capacity, from ERR
        tx = '{8'hA5, 8'h01, 8'h00};
        for (int k = 0; k < 256; k++) begin
            tx.push_back(8'(k));
            tx.push_back(~8'(k));
        end
        tx.push_back(8'hFF);
        model_tx();
        wr_count = 0;
        send_range(0, tx.size() - 1);
        check_status("full");
        chk("full_wr_count",   wr_count,   256);
        chk("full_last_waddr", last_waddr, 255);
        do_reload();

        // Stall one cycle short of the timeout, then finish
        tx = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'hB9};
        model_tx();
        send_range(0, 3);
        repeat (TIMEOUT - 1) @(posedge clk);
        #1;
        chk("stall_short_err", int'(err), 0);
        send_range(4, 5);
        check_status("stall_short");
        do_reload();

        // Stall reaching the timeout after the first data byte
        tx = '{8'hA5, 8'h00, 8'h02, 8'h12};
        send_range(0, 3);
        repeat (TIMEOUT - 1) @(posedge clk);
        #1;
        chk("tmo_before_err", int'(err), 0);
        @(posedge clk);
        #1;
        chk("tmo_err",     int'(err),     1);
        chk("tmo_cpu_rst", int'(cpu_rst), 1);
        chk("tmo_done",    int'(done),    0);

        // Asynchronous reset while in DATA_L
        tx = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
        exp_addr.push_back(0);
        exp_data.push_back('h1122);
        send_range(0, 5);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_imem_we",    int'(imem_we),    0);
        chk("arst_imem_waddr", int'(imem_waddr), 0);
        chk("arst_imem_wdata", int'(imem_wdata), 0);
        chk("arst_cpu_rst",    int'(cpu_rst),    1);
        chk("arst_done",       int'(done),       0);
        chk("arst_err",        int'(err),        0);
        chk("arst_in_ready",   int'(in_ready),   1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        tx = '{8'hA5, 8'h00, 8'h01, 8'hCA, 8'hFE, 8'h37};
        model_tx();
        wr_count = 0;
        send_range(0, 5);
        check_status("after_rst");
        chk("after_rst_waddr", last_waddr, 0);
        chk("after_rst_wdata", last_wdata, 'hCAFE);
        chk("after_rst_wr_count", wr_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
